// File: rtl/noc_pkg.sv
// Shared NoC bridge definitions: widths and the Wishbone register map.
package noc_pkg;

  localparam int NOC_WID = 16;
  localparam int TAG_W   = 8;

  // Register addresses decoded by the Wishbone interface feeding this bridge
  localparam logic [31:0] NOC_RX_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] NOC_TX_ADDR = 32'hFFFF_0004;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary pointers, separate occupancy count and sync flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_data    = o_empty ? '0 : r_mem[r_rd];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Pointer and occupancy bookkeeping; flush discards everything queued
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage write; contents need no reset because the count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/noc_wb_bridge.sv
// Bridge between the toggle-signalled Wishbone NoC registers and valid/ready
// router streams, with one FIFO per direction and sticky error flags.
module noc_wb_bridge
  import noc_pkg::*;
#(
  parameter int NOC_WID = noc_pkg::NOC_WID,
  parameter int DEPTH   = 4,
  parameter int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               en,
  input  logic [NOC_WID-1:0] noc_rx,
  input  logic [TAG_W-1:0]   noc_rx_bits,
  input  logic               noc_rx_toggle,
  output logic [NOC_WID-1:0] noc_tx,
  input  logic               noc_tx_toggle,
  output logic [NOC_WID-1:0] out_flit_o,
  output logic [TAG_W-1:0]   out_tag_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  input  logic [NOC_WID-1:0] in_flit_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [LVL_W-1:0]   rx_level_o,
  output logic [LVL_W-1:0]   tx_level_o,
  output logic               rx_overflow_o,
  output logic               tx_underflow_o
);

  localparam int RXW = NOC_WID + TAG_W;

  logic           r_rx_tog;
  logic           r_tx_tog;
  logic           r_rx_ovf;
  logic           r_tx_unf;
  logic           w_rx_evt;
  logic           w_tx_evt;
  logic           w_flush;
  logic           w_rx_full;
  logic           w_rx_empty;
  logic           w_rx_pop;
  logic           w_tx_full;
  logic           w_tx_empty;
  logic           w_tx_push;
  logic [RXW-1:0] w_rx_head;

  assign w_flush  = ~en;
  assign w_rx_evt = en & (noc_rx_toggle ^ r_rx_tog);
  assign w_tx_evt = en & (noc_tx_toggle ^ r_tx_tog);

  assign out_valid_o = en & ~w_rx_empty;
  assign w_rx_pop    = out_valid_o & out_ready_i;
  assign {out_tag_o, out_flit_o} = w_rx_head;

  assign in_ready_o = en & ~w_tx_full;
  assign w_tx_push  = in_valid_i & in_ready_o;

  assign rx_overflow_o  = r_rx_ovf;
  assign tx_underflow_o = r_tx_unf;

  // Toggle history tracks the inputs every cycle, so en=0 absorbs the
  // interface's own toggle clear without producing an event
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rx_tog <= 1'b0;
      r_tx_tog <= 1'b0;
    end else begin
      r_rx_tog <= noc_rx_toggle;
      r_tx_tog <= noc_tx_toggle;
    end
  end

  // Sticky error flags, cleared whenever the bridge is disabled
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_rx_ovf <= 1'b0;
      r_tx_unf <= 1'b0;
    end else if (!en) begin
      r_rx_ovf <= 1'b0;
      r_tx_unf <= 1'b0;
    end else begin
      if (w_rx_evt && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
      if (w_tx_evt && w_tx_empty)             r_tx_unf <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(RXW), .DEPTH(DEPTH)) u_rx_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_flush (w_flush),
    .i_push  (w_rx_evt),
    .i_data  ({noc_rx_bits, noc_rx}),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (rx_level_o)
  );

  sync_fifo #(.WIDTH(NOC_WID), .DEPTH(DEPTH)) u_tx_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_flush (w_flush),
    .i_push  (w_tx_push),
    .i_data  (in_flit_i),
    .i_pop   (w_tx_evt),
    .o_data  (noc_tx),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (tx_level_o)
  );

endmodule

// File: tb/tb_noc_wb_bridge.sv
// Self-checking bench for noc_wb_bridge: stimulus tables plus scoreboards.
module tb_noc_wb_bridge;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] noc_rx;
  logic [7:0]  noc_rx_bits;
  logic        noc_rx_toggle;
  logic [15:0] noc_tx;
  logic        noc_tx_toggle;
  logic [15:0] out_flit;
  logic [7:0]  out_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  rx_level;
  logic [2:0]  tx_level;
  logic        rx_ovf;
  logic        tx_unf;

  noc_wb_bridge dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .en             (en),
    .noc_rx         (noc_rx),
    .noc_rx_bits    (noc_rx_bits),
    .noc_rx_toggle  (noc_rx_toggle),
    .noc_tx         (noc_tx),
    .noc_tx_toggle  (noc_tx_toggle),
    .out_flit_o     (out_flit),
    .out_tag_o      (out_tag),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .in_flit_i      (in_flit),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .rx_level_o     (rx_level),
    .tx_level_o     (tx_level),
    .rx_overflow_o  (rx_ovf),
    .tx_underflow_o (tx_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] flit;
    logic [7:0]  tag;
    int          exp_lvl;
    logic        exp_ovf;
    logic        accept;
  } rx_vec_t;

  rx_vec_t     rx_tab [5];
  logic [15:0] tx_tab [5];
  logic [23:0] rx_sb [$];
  logic [15:0] tx_sb [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_send(input logic [15:0] flit, input logic [7:0] tag);
    noc_rx        = flit;
    noc_rx_bits   = tag;
    noc_rx_toggle = ~noc_rx_toggle;
    tick();
    noc_rx      = '0;
    noc_rx_bits = '0;
  endtask

  task automatic rx_drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rx_drain_valid", {31'd0, out_valid}, 32'd1);
      if (rx_sb.size() > 0) begin
        check("rx_drain_data", {8'd0, out_tag, out_flit}, {8'd0, rx_sb[0]});
        void'(rx_sb.pop_front());
      end else begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_drain_sb: got output with empty scoreboard");
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic tx_push(input logic [15:0] flit);
    logic exp_rdy;
    in_flit  = flit;
    in_valid = 1'b1;
    @(negedge clk);
    exp_rdy = (tx_sb.size() < 4);
    check("tx_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) tx_sb.push_back(flit);
    tick();
    in_valid = 1'b0;
    in_flit  = '0;
  endtask

  // Read noc_tx, flip the toggle on the sampling edge, then let the pop land
  task automatic tx_read();
    logic [15:0] exp_word;
    @(negedge clk);
    exp_word = (tx_sb.size() > 0) ? tx_sb[0] : 16'h0;
    check("tx_read_data", {16'd0, noc_tx}, {16'd0, exp_word});
    tick();
    noc_tx_toggle = ~noc_tx_toggle;
    if (tx_sb.size() > 0) void'(tx_sb.pop_front());
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      rx_tab[i].flit    = 16'(i + 1);
      rx_tab[i].tag     = 8'(8'hA0 + i);
      rx_tab[i].exp_lvl = (i < 4) ? i + 1 : 4;
      rx_tab[i].exp_ovf = (i == 4);
      rx_tab[i].accept  = (i < 4);
      tx_tab[i]         = 16'(16'hC000 + i);
    end

    rst_n = 1'b0; en = 1'b1;
    noc_rx = '0; noc_rx_bits = '0; noc_rx_toggle = 1'b0; noc_tx_toggle = 1'b0;
    out_ready = 1'b0; in_flit = '0; in_valid = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_noc_tx", {16'd0, noc_tx}, 32'd0);
    check("rst_levels", {26'd0, rx_level, tx_level}, 32'd0);
    check("rst_flags", {30'd0, rx_ovf, tx_unf}, 32'd0);
    rst_n = 1'b1;
    tick();

    // RX single word
    rx_send(16'hBEEF, 8'h10);
    rx_sb.push_back({8'h10, 16'hBEEF});
    @(negedge clk);
    check("rx1_valid", {31'd0, out_valid}, 32'd1);
    check("rx1_flit", {16'd0, out_flit}, 32'hBEEF);
    check("rx1_tag", {24'd0, out_tag}, 32'h10);
    check("rx1_level", {29'd0, rx_level}, 32'd1);
    tick();
    rx_drain(1);
    @(negedge clk);
    check("rx1_level_after", {29'd0, rx_level}, 32'd0);
    check("rx1_valid_after", {31'd0, out_valid}, 32'd0);
    tick();

    // RX overflow, table-driven
    for (int i = 0; i < 5; i++) begin
      rx_send(rx_tab[i].flit, rx_tab[i].tag);
      if (rx_tab[i].accept) rx_sb.push_back({rx_tab[i].tag, rx_tab[i].flit});
      @(negedge clk);
      check("ovf_level", {29'd0, rx_level}, 32'(rx_tab[i].exp_lvl));
      check("ovf_flag", {31'd0, rx_ovf}, {31'd0, rx_tab[i].exp_ovf});
      tick();
    end
    rx_drain(4);
    @(negedge clk);
    check("ovf_drained_level", {29'd0, rx_level}, 32'd0);
    check("ovf_sticky", {31'd0, rx_ovf}, 32'd1);
    tick();

    // Clear the flag with one disabled cycle, then push-while-full with a pop
    en = 1'b0;
    tick();
    en = 1'b1;
    @(negedge clk);
    check("ovf_cleared", {31'd0, rx_ovf}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      rx_send(16'h0100 + 16'(i), 8'h50);
      rx_sb.push_back({8'h50, 16'h0100 + 16'(i)});
    end
    out_ready     = 1'b1;
    noc_rx        = 16'h0200;
    noc_rx_bits   = 8'h51;
    noc_rx_toggle = ~noc_rx_toggle;
    @(negedge clk);
    check("fullpop_head", {8'd0, out_tag, out_flit}, {8'd0, rx_sb[0]});
    void'(rx_sb.pop_front());
    rx_sb.push_back({8'h51, 16'h0200});
    tick();
    out_ready = 1'b0; noc_rx = '0; noc_rx_bits = '0;
    @(negedge clk);
    check("fullpop_level", {29'd0, rx_level}, 32'd4);
    check("fullpop_no_ovf", {31'd0, rx_ovf}, 32'd0);
    tick();
    rx_drain(4);

    // TX read / pop
    tx_push(16'h1234);
    tx_push(16'h5678);
    @(negedge clk);
    check("tx_level2", {29'd0, tx_level}, 32'd2);
    tick();
    tx_read();
    @(negedge clk);
    check("tx_after_pop1", {16'd0, noc_tx}, 32'h5678);
    check("tx_level1", {29'd0, tx_level}, 32'd1);
    tick();
    tx_read();
    @(negedge clk);
    check("tx_after_pop2", {16'd0, noc_tx}, 32'h0);
    check("tx_level0", {29'd0, tx_level}, 32'd0);
    tick();

    // TX underflow
    tx_read();
    @(negedge clk);
    check("tx_unf_flag", {31'd0, tx_unf}, 32'd1);
    check("tx_unf_data", {16'd0, noc_tx}, 32'h0);
    check("tx_unf_level", {29'd0, tx_level}, 32'd0);
    tick();

    // TX backpressure: fifth push refused
    for (int i = 0; i < 5; i++) tx_push(tx_tab[i]);
    @(negedge clk);
    check("tx_full_level", {29'd0, tx_level}, 32'd4);
    check("tx_full_ready", {31'd0, in_ready}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) tx_read();
    @(negedge clk);
    check("tx_drained", {29'd0, tx_level}, 32'd0);
    tick();

    // en gating: align toggles to 1 while disabled, then fill both FIFOs
    en = 1'b0; noc_rx_toggle = 1'b1; noc_tx_toggle = 1'b1;
    tick();
    en = 1'b1;
    tick();
    rx_send(16'hAAAA, 8'h01);
    rx_send(16'hBBBB, 8'h02);
    tx_push(16'h1111);
    tx_push(16'h2222);
    @(negedge clk);
    check("en_pre_levels", {26'd0, rx_level, tx_level}, {26'd0, 3'd2, 3'd2});
    tick();
    en = 1'b0; noc_rx_toggle = 1'b0; noc_tx_toggle = 1'b0;
    @(negedge clk);
    check("en_off_handshake", {30'd0, out_valid, in_ready}, 32'd0);
    tick();
    en = 1'b1;
    rx_sb.delete();
    tx_sb.delete();
    @(negedge clk);
    check("en_levels", {26'd0, rx_level, tx_level}, 32'd0);
    check("en_flags", {30'd0, rx_ovf, tx_unf}, 32'd0);
    tick();
    @(negedge clk);
    check("en_no_spurious", {26'd0, rx_level, tx_level}, 32'd0);
    check("en_no_spurious_flags", {30'd0, rx_ovf, tx_unf}, 32'd0);
    tick();

    // Async reset mid-stream
    rx_send(16'hCAFE, 8'h77);
    tx_push(16'h9999);
    check("ar_valid_before", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid_after", {31'd0, out_valid}, 32'd0);
    check("ar_levels", {26'd0, rx_level, tx_level}, 32'd0);
    check("ar_noc_tx", {16'd0, noc_tx}, 32'd0);
    rx_sb.delete();
    tx_sb.delete();
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
